// File: rtl/rain_display_scan_pkg.sv
// Shared types and constants for the rain gauge display scanner.
// Holds the scan FSM state type, 7-segment codes and digit positions.
package rain_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam logic [2:0] POS_HUNDREDS   = 3'd0;
  localparam logic [2:0] POS_TENS       = 3'd1;
  localparam logic [2:0] POS_UNITS      = 3'd2;
  localparam logic [2:0] POS_TENTHS     = 3'd3;
  localparam logic [2:0] POS_HUNDREDTHS = 3'd4;
  localparam logic [2:0] DP_POS         = 3'd2;

  // One-hot digit enable; anything outside 0..4 enables nothing.
  function automatic logic [4:0] pos_onehot(input logic [2:0] pos);
    logic [4:0] sel;
    case (pos)
      POS_HUNDREDS:   sel = 5'b00001;
      POS_TENS:       sel = 5'b00010;
      POS_UNITS:      sel = 5'b00100;
      POS_TENTHS:     sel = 5'b01000;
      POS_HUNDREDTHS: sel = 5'b10000;
      default:        sel = 5'b00000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rain_display_scan_bcd_to_7seg.sv
// BCD digit to active-high 7-segment pattern (bit0=a .. bit6=g).
// Codes 10..15 are shown as a dash so a corrupt digit is visible.
module bcd_to_7seg
  import rain_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Segment lookup with dash as the fallback for non-decimal codes.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/rain_display_scan.sv
// Multiplexed 5-digit scanner for the rain gauge reading (ddd.dd mm).
// Digits are snapshotted once per frame; each slot is SHOW then BLANK.
module rain_display_scan
  import rain_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 32'd64,
  parameter int unsigned BLANK_CYCLES = 32'd4,
  parameter int unsigned LZB_EN       = 32'd1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [3:0] rain_hundreds_bcd,
  input  logic [3:0] rain_tens_bcd,
  input  logic [3:0] rain_units_bcd,
  input  logic [3:0] rain_tenths_bcd,
  input  logic [3:0] rain_hundredths_bcd,
  output logic [6:0] seg,
  output logic       dp,
  output logic [4:0] digit_sel,
  output logic       frame_start
);

  localparam logic [9:0] SHOW_LAST_C  = 10'(SCAN_DIV - BLANK_CYCLES - 32'd1);
  localparam logic [9:0] BLANK_LAST_C = 10'(BLANK_CYCLES - 32'd1);
  localparam bit         HAS_BLANK_C  = (BLANK_CYCLES != 32'd0);
  localparam bit         LZB_C        = (LZB_EN != 32'd0);

  scan_state_t       state_r, state_s;
  logic [2:0]        pos_r, pos_s, next_pos_s;
  logic [9:0]        cnt_r, cnt_s;
  logic [4:0][3:0]   snap_r, snap_s, next_snap_s, live_s;
  logic              wrap_s;
  logic [3:0]        digit_s;
  logic [6:0]        dec_seg_s;
  logic              lzb_s;

  // Element n of the snapshot is display position n.
  assign live_s = {rain_hundredths_bcd, rain_tenths_bcd, rain_units_bcd,
                   rain_tens_bcd, rain_hundreds_bcd};

  // Leaving the last position starts a new frame, which is when inputs are re-latched.
  assign wrap_s      = (pos_r >= POS_HUNDREDTHS);
  assign next_pos_s  = wrap_s ? POS_HUNDREDS : (pos_r + 3'd1);
  assign next_snap_s = wrap_s ? live_s : snap_r;

  // State, position, slot counter and snapshot registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= IDLE;
      pos_r   <= 3'd0;
      cnt_r   <= 10'd0;
      snap_r  <= 20'h0;
    end else begin
      state_r <= state_s;
      pos_r   <= pos_s;
      cnt_r   <= cnt_s;
      snap_r  <= snap_s;
    end
  end

  // Scan sequencing: SHOW for the lit part of a slot, BLANK for the gap.
  always_comb begin
    state_s = state_r;
    pos_s   = pos_r;
    cnt_s   = cnt_r;
    snap_s  = snap_r;
    if (!Enable) begin
      state_s = IDLE;
      pos_s   = POS_HUNDREDS;
      cnt_s   = 10'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = SHOW;
          pos_s   = POS_HUNDREDS;
          cnt_s   = 10'd0;
          snap_s  = live_s;
        end
        SHOW: begin
          if (cnt_r != SHOW_LAST_C) begin
            cnt_s = cnt_r + 10'd1;
          end else if (HAS_BLANK_C) begin
            state_s = BLANK;
            cnt_s   = 10'd0;
          end else begin
            state_s = SHOW;
            cnt_s   = 10'd0;
            pos_s   = next_pos_s;
            snap_s  = next_snap_s;
          end
        end
        BLANK: begin
          if (cnt_r != BLANK_LAST_C) begin
            cnt_s = cnt_r + 10'd1;
          end else begin
            state_s = SHOW;
            cnt_s   = 10'd0;
            pos_s   = next_pos_s;
            snap_s  = next_snap_s;
          end
        end
        default: begin
          state_s = IDLE;
          pos_s   = POS_HUNDREDS;
          cnt_s   = 10'd0;
        end
      endcase
    end
  end

  // Select the snapshot digit for the current position.
  always_comb begin
    digit_s = 4'd0;
    case (pos_r)
      POS_HUNDREDS:   digit_s = snap_r[0];
      POS_TENS:       digit_s = snap_r[1];
      POS_UNITS:      digit_s = snap_r[2];
      POS_TENTHS:     digit_s = snap_r[3];
      POS_HUNDREDTHS: digit_s = snap_r[4];
      default:        digit_s = 4'd0;
    endcase
  end

  bcd_to_7seg u_bcd_to_7seg (
    .bcd (digit_s),
    .seg (dec_seg_s)
  );

  // Only the two leftmost positions can be blanked, so 0.00 stays readable.
  assign lzb_s = LZB_C &&
                 (((pos_r == POS_HUNDREDS) && (snap_r[0] == 4'd0)) ||
                  ((pos_r == POS_TENS) && (snap_r[0] == 4'd0) && (snap_r[1] == 4'd0)));

  // Output decode from registered state; dark outside SHOW.
  always_comb begin
    seg         = SEG_OFF;
    dp          = 1'b0;
    digit_sel   = 5'b00000;
    frame_start = 1'b0;
    case (state_r)
      SHOW: begin
        digit_sel = pos_onehot(pos_r);
        if (lzb_s) begin
          seg = SEG_OFF;
        end else begin
          seg = dec_seg_s;
        end
        dp          = (pos_r == DP_POS);
        frame_start = (pos_r == POS_HUNDREDS) && (cnt_r == 10'd0);
      end
      IDLE, BLANK: begin
        seg         = SEG_OFF;
        digit_sel   = 5'b00000;
      end
      default: begin
        seg         = SEG_OFF;
        digit_sel   = 5'b00000;
      end
    endcase
  end

endmodule

// File: tb/tb_rain_display_scan.sv
// Self-checking bench for rain_display_scan: two instances (default and a short,
// gapless, no-blanking variant) compared each cycle with a frame-time model.
module tb_rain_display_scan;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b0;
  logic [3:0] d_h = 4'd0, d_t = 4'd0, d_u = 4'd0, d_te = 4'd0, d_hu = 4'd0;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fs_a, fs_b;
  logic [4:0] sel_a, sel_b;

  int n_pass = 0;
  int n_total = 0;

  rain_display_scan #(.SCAN_DIV(64), .BLANK_CYCLES(4), .LZB_EN(1)) dut_a (
    .Clock(Clock), .Reset(Reset), .Enable(Enable),
    .rain_hundreds_bcd(d_h), .rain_tens_bcd(d_t), .rain_units_bcd(d_u),
    .rain_tenths_bcd(d_te), .rain_hundredths_bcd(d_hu),
    .seg(seg_a), .dp(dp_a), .digit_sel(sel_a), .frame_start(fs_a));

  rain_display_scan #(.SCAN_DIV(8), .BLANK_CYCLES(0), .LZB_EN(0)) dut_b (
    .Clock(Clock), .Reset(Reset), .Enable(Enable),
    .rain_hundreds_bcd(d_h), .rain_tens_bcd(d_t), .rain_units_bcd(d_u),
    .rain_tenths_bcd(d_te), .rain_hundredths_bcd(d_hu),
    .seg(seg_b), .dp(dp_b), .digit_sel(sel_b), .frame_start(fs_b));

  always #5 Clock = ~Clock;

  // Reference model: time since frame start plus a per-frame digit snapshot.
  int         div_p [2] = '{64, 8};
  int         blk_p [2] = '{4, 0};
  bit         lzb_p [2] = '{1'b1, 1'b0};
  bit         run_m [2] = '{1'b0, 1'b0};
  int         t_m   [2] = '{0, 0};
  logic [3:0] snap_m [2][5];
  logic [13:0] exp_v [2] = '{14'h0, 14'h0};
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  function automatic logic [13:0] expect_out(input int i);
    int slot, w;
    logic [6:0] s;
    if (!run_m[i]) return 14'h0;
    slot = t_m[i] / div_p[i];
    w    = t_m[i] % div_p[i];
    if (w >= div_p[i] - blk_p[i]) return 14'h0;
    s = seg_tab[snap_m[i][slot]];
    if (lzb_p[i] && slot == 0 && snap_m[i][0] == 4'd0) s = 7'h00;
    if (lzb_p[i] && slot == 1 && snap_m[i][0] == 4'd0 && snap_m[i][1] == 4'd0) s = 7'h00;
    return {s, slot == 2, 5'(1 << slot), t_m[i] == 0};
  endfunction

  always @(posedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset || !Enable) begin
        run_m[i] = 1'b0;
      end else if (!run_m[i]) begin
        run_m[i] = 1'b1;
        t_m[i] = 0;
        snap_m[i] = '{d_h, d_t, d_u, d_te, d_hu};
      end else begin
        t_m[i] = (t_m[i] + 1) % (5 * div_p[i]);
        if (t_m[i] == 0) snap_m[i] = '{d_h, d_t, d_u, d_te, d_hu};
      end
      exp_v[i] = expect_out(i);
    end
  end

  task automatic restart_scan();
    Enable = 1'b0;
    @(negedge Clock);
    Enable = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Enable = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      n_total++;
      if ({seg_a, dp_a, sel_a, fs_a} !== 14'h0)
        $display("FAIL reset_dark_a c=%0d got %h exp 0", c, {seg_a, dp_a, sel_a, fs_a});
      else n_pass++;
      n_total++;
      if ({seg_b, dp_b, sel_b, fs_b} !== 14'h0)
        $display("FAIL reset_dark_b c=%0d got %h exp 0", c, {seg_b, dp_b, sel_b, fs_b});
      else n_pass++;
    end
  endtask

  task automatic test_frame();
    int on_cnt = 0, fs_cnt = 0;
    logic [13:0] exp_d;
    bit chk;
    {d_h, d_t, d_u, d_te, d_hu} = {4'd0, 4'd0, 4'd0, 4'd2, 4'd8};
    Enable = 1'b1;
    for (int c = 0; c < 640; c++) begin
      @(negedge Clock);
      n_total++;
      if ({seg_a, dp_a, sel_a, fs_a} !== exp_v[0])
        $display("FAIL frame_model_a c=%0d got %h exp %h", c, {seg_a, dp_a, sel_a, fs_a}, exp_v[0]);
      else n_pass++;
      n_total++;
      if ({seg_b, dp_b, sel_b, fs_b} !== exp_v[1])
        $display("FAIL frame_model_b c=%0d got %h exp %h", c, {seg_b, dp_b, sel_b, fs_b}, exp_v[1]);
      else n_pass++;
      chk = 1'b1; exp_d = 14'h0;
      case (c)
        0:       exp_d = {7'h00, 1'b0, 5'b00001, 1'b1};
        64:      exp_d = {7'h00, 1'b0, 5'b00010, 1'b0};
        130:     exp_d = {7'h3F, 1'b1, 5'b00100, 1'b0};
        200:     exp_d = {7'h5B, 1'b0, 5'b01000, 1'b0};
        253:     exp_d = 14'h0;
        260:     exp_d = {7'h7F, 1'b0, 5'b10000, 1'b0};
        320:     exp_d = {7'h00, 1'b0, 5'b00001, 1'b1};
        default: chk = 1'b0;
      endcase
      if (chk) begin
        n_total++;
        if ({seg_a, dp_a, sel_a, fs_a} !== exp_d)
          $display("FAIL frame_point c=%0d got %h exp %h", c, {seg_a, dp_a, sel_a, fs_a}, exp_d);
        else n_pass++;
      end
      if (sel_a != 5'd0) on_cnt++;
      if (fs_a) fs_cnt++;
    end
    n_total++;
    if (on_cnt != 600) $display("FAIL frame_on_cycles got %0d exp 600", on_cnt);
    else n_pass++;
    n_total++;
    if (fs_cnt != 2) $display("FAIL frame_start_count got %0d exp 2", fs_cnt);
    else n_pass++;
  endtask

  task automatic test_snapshot();
    logic [13:0] exp_d;
    bit chk;
    for (int c = 0; c <= 320; c++) begin
      @(negedge Clock);
      n_total++;
      if ({seg_a, dp_a, sel_a, fs_a} !== exp_v[0])
        $display("FAIL snap_model_a c=%0d got %h exp %h", c, {seg_a, dp_a, sel_a, fs_a}, exp_v[0]);
      else n_pass++;
      chk = 1'b1; exp_d = 14'h0;
      case (c)
        130:     exp_d = {7'h3F, 1'b1, 5'b00100, 1'b0};
        300:     exp_d = {7'h7F, 1'b0, 5'b10000, 1'b0};
        320:     exp_d = {7'h06, 1'b0, 5'b00001, 1'b1};
        default: chk = 1'b0;
      endcase
      if (chk) begin
        n_total++;
        if ({seg_a, dp_a, sel_a, fs_a} !== exp_d)
          $display("FAIL snap_point c=%0d got %h exp %h", c, {seg_a, dp_a, sel_a, fs_a}, exp_d);
        else n_pass++;
      end
      if (c == 100) {d_h, d_t, d_u, d_te, d_hu} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    end
  endtask

  task automatic test_lzb();
    logic [3:0] hs [3] = '{4'd0, 4'd1, 4'd0};
    logic [3:0] ts [3] = '{4'd5, 4'd0, 4'd0};
    logic [6:0] a0 [3] = '{7'h00, 7'h06, 7'h00};
    logic [6:0] a1 [3] = '{7'h6D, 7'h3F, 7'h00};
    logic [6:0] b0 [3] = '{7'h3F, 7'h06, 7'h3F};
    logic [6:0] b1 [3] = '{7'h6D, 7'h3F, 7'h3F};
    for (int k = 0; k < 3; k++) begin
      {d_h, d_t, d_u, d_te, d_hu} = {hs[k], ts[k], 4'd3, 4'd7, 4'd9};
      restart_scan();
      for (int c = 0; c <= 70; c++) begin
        @(negedge Clock);
        n_total++;
        if ({seg_b, dp_b, sel_b, fs_b} !== exp_v[1])
          $display("FAIL lzb_model_b k=%0d c=%0d got %h exp %h", k, c, {seg_b, dp_b, sel_b, fs_b}, exp_v[1]);
        else n_pass++;
        if (c == 0) begin
          n_total += 2;
          if ({seg_a, sel_a} !== {a0[k], 5'b00001}) $display("FAIL lzb_a_pos0 k=%0d got %h exp %h", k, seg_a, a0[k]);
          else n_pass++;
          if ({seg_b, sel_b} !== {b0[k], 5'b00001}) $display("FAIL lzb_b_pos0 k=%0d got %h exp %h", k, seg_b, b0[k]);
          else n_pass++;
        end
        if (c == 9) begin
          n_total++;
          if ({seg_b, sel_b} !== {b1[k], 5'b00010}) $display("FAIL lzb_b_pos1 k=%0d got %h exp %h", k, seg_b, b1[k]);
          else n_pass++;
        end
        if (c == 65) begin
          n_total++;
          if ({seg_a, sel_a} !== {a1[k], 5'b00010}) $display("FAIL lzb_a_pos1 k=%0d got %h exp %h", k, seg_a, a1[k]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_invalid();
    logic [13:0] exp_d;
    bit chk;
    {d_h, d_t, d_u, d_te, d_hu} = {4'd4, 4'd1, 4'd7, 4'hA, 4'd2};
    restart_scan();
    for (int c = 0; c < 320; c++) begin
      @(negedge Clock);
      n_total++;
      if ({seg_b, dp_b, sel_b, fs_b} !== exp_v[1])
        $display("FAIL inv_model_b c=%0d got %h exp %h", c, {seg_b, dp_b, sel_b, fs_b}, exp_v[1]);
      else n_pass++;
      chk = 1'b1; exp_d = 14'h0;
      case (c)
        5:       exp_d = {7'h66, 1'b0, 5'b00001, 1'b0};
        69:      exp_d = {7'h06, 1'b0, 5'b00010, 1'b0};
        133:     exp_d = {7'h07, 1'b1, 5'b00100, 1'b0};
        197:     exp_d = {7'h40, 1'b0, 5'b01000, 1'b0};
        261:     exp_d = {7'h5B, 1'b0, 5'b10000, 1'b0};
        default: chk = 1'b0;
      endcase
      if (chk) begin
        n_total++;
        if ({seg_a, dp_a, sel_a, fs_a} !== exp_d)
          $display("FAIL invalid_point c=%0d got %h exp %h", c, {seg_a, dp_a, sel_a, fs_a}, exp_d);
        else n_pass++;
      end
    end
  endtask

  task automatic test_interrupt();
    {d_h, d_t, d_u, d_te, d_hu} = {4'd9, 4'd8, 4'd7, 4'd6, 4'd5};
    restart_scan();
    repeat (201) @(negedge Clock);
    Enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      n_total++;
      if ({seg_a, dp_a, sel_a, fs_a} !== 14'h0)
        $display("FAIL enable_drop_dark k=%0d got %h exp 0", k, {seg_a, dp_a, sel_a, fs_a});
      else n_pass++;
    end
    Enable = 1'b1;
    @(negedge Clock);
    n_total++;
    if ({seg_a, dp_a, sel_a, fs_a} !== {7'h6F, 1'b0, 5'b00001, 1'b1})
      $display("FAIL enable_restart got %h exp %h", {seg_a, dp_a, sel_a, fs_a}, {7'h6F, 1'b0, 5'b00001, 1'b1});
    else n_pass++;
    repeat (70) @(negedge Clock);
    n_total++;
    if (sel_a !== 5'b00010) $display("FAIL pre_reset_pos1 got %b exp 00010", sel_a);
    else n_pass++;
    Reset = 1'b1;
    @(negedge Clock);
    n_total += 2;
    if ({seg_a, dp_a, sel_a, fs_a} !== 14'h0)
      $display("FAIL reset_mid_dark got %h exp 0", {seg_a, dp_a, sel_a, fs_a});
    else n_pass++;
    if ({seg_b, dp_b, sel_b, fs_b} !== 14'h0)
      $display("FAIL reset_mid_dark_b got %h exp 0", {seg_b, dp_b, sel_b, fs_b});
    else n_pass++;
    Reset = 1'b0;
    @(negedge Clock);
    n_total++;
    if ({seg_a, dp_a, sel_a, fs_a} !== {7'h6F, 1'b0, 5'b00001, 1'b1})
      $display("FAIL reset_restart got %h exp %h", {seg_a, dp_a, sel_a, fs_a}, {7'h6F, 1'b0, 5'b00001, 1'b1});
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      @(negedge Clock);
      n_total++;
      if ({seg_a, dp_a, sel_a, fs_a} !== exp_v[0])
        $display("FAIL rand_model_a c=%0d got %h exp %h", c, {seg_a, dp_a, sel_a, fs_a}, exp_v[0]);
      else n_pass++;
      n_total++;
      if ({seg_b, dp_b, sel_b, fs_b} !== exp_v[1])
        $display("FAIL rand_model_b c=%0d got %h exp %h", c, {seg_b, dp_b, sel_b, fs_b}, exp_v[1]);
      else n_pass++;
      if ($urandom_range(0, 29) == 0) begin
        d_h  = 4'($urandom_range(0, 15));
        d_t  = 4'($urandom_range(0, 15));
        d_u  = 4'($urandom_range(0, 15));
        d_te = 4'($urandom_range(0, 15));
        d_hu = 4'($urandom_range(0, 15));
      end
      if (Enable) begin
        if ($urandom_range(0, 499) == 0) Enable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) Enable = 1'b1;
      if (Reset) Reset = 1'b0;
      else if ($urandom_range(0, 999) == 0) Reset = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_snapshot();
    test_lzb();
    test_invalid();
    test_interrupt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rain_display_scan.md
Name: rain_display_scan

Overview:
- Downstream of the rain gauge. Consumes its five BCD digits (ddd.dd mm) and drives a 5-digit multiplexed 7-segment display.
- Scans one digit at a time, with an anti-ghosting blank gap between digits.
- Snapshots the input digits once per frame, so a frame never shows a mix of old and new digits.
- Blanks leading zeros and lights the decimal point on the units digit.

Parameters:
- SCAN_DIV, 64: Clock cycles per digit slot, SHOW plus BLANK. At 32.768 kHz this gives about a 102 Hz frame rate. Legal range 2..1023.
- BLANK_CYCLES, 4: Cycles per slot with all digits off. Legal range 0..SCAN_DIV-1.
- LZB_EN, 1: 1 enables leading-zero blanking on positions 0 and 1.

Ports:
- Clock input 1: system clock, 32.768 kHz.
- Reset input 1: synchronous, active-high reset.
- Enable input 1: 1 = display scanning, 0 = display dark.
- rain_hundreds_bcd input 4: position 0, leftmost digit.
- rain_tens_bcd input 4: position 1.
- rain_units_bcd input 4: position 2; its decimal point is lit.
- rain_tenths_bcd input 4: position 3.
- rain_hundredths_bcd input 4: position 4, rightmost digit.
- seg output 7: segments, active-high; bit0=a through bit6=g.
- dp output 1: decimal point, active-high.
- digit_sel output 5: one-hot digit enable, active-high; bit n = position n.
- frame_start output 1: one-cycle pulse on the first SHOW cycle of position 0.

Behaviour:
- Reset is synchronous and active-high on Clock. It forces state=IDLE, pos=0, cnt=0 and snapshot=0.
- Outputs are combinational decodes of registered state, pos, cnt and snapshot. Every output is 0 in the cycle after a Reset edge.
- Reset asserted mid-frame aborts the frame; the next cycle is dark.
- The FSM has three states:
  - IDLE: seg, dp, digit_sel and frame_start are all 0.
  - SHOW: digit_sel=1<<pos; seg and dp are driven.
  - BLANK: digit_sel=0, seg=0, dp=0.
- Transitions, evaluated at each Clock edge (Reset has priority):
  - Enable=0 in any state -> IDLE next cycle, even mid-frame.
  - IDLE with Enable=1 -> SHOW with pos=0, cnt=0, and all 5 inputs latched into the snapshot.
  - SHOW with cnt==SCAN_DIV-BLANK_CYCLES-1 -> BLANK with cnt=0. If BLANK_CYCLES==0, skip BLANK and advance directly as below.
  - BLANK with cnt==BLANK_CYCLES-1 -> SHOW, pos+1, cnt=0.
  - When advancing from pos==4, wrap to pos=0 and re-latch the snapshot on that same edge.
  - Otherwise cnt increments.
- Timing:
  - frame_start = (state==SHOW && pos==0 && cnt==0).
  - Frame period is 5*SCAN_DIV cycles.
  - First frame_start occurs 1 cycle after the edge where Enable is sampled high.
- The snapshot is the only source of displayed digits. Input changes between latches are invisible until the next frame.
- Segment code per digit:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - BCD 10..15 shows '-' (0x40).
- Leading-zero blanking (LZB_EN=1), evaluated on the snapshot:
  - Position 0 shows seg=0 if hundreds==0.
  - Position 1 shows seg=0 if hundreds==0 and tens==0.
  - Positions 2..4 are never blanked, so 0.00 is displayed.
  - digit_sel still asserts for blanked positions; only seg is zero.
- dp=1 only in SHOW with pos==2.
- Counter cnt is 10 bits and never exceeds SCAN_DIV-1. pos is 3 bits and takes values 0..4 only.

Decomposition:
- Package rain_display_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHOW, BLANK} scan_state_t;
  - segment constants SEG_0..SEG_9, SEG_DASH=7'h40, SEG_OFF=7'h00;
  - position constants POS_HUNDREDS=0 through POS_HUNDREDTHS=4, and DP_POS=2.
- Sub-module bcd_to_7seg: combinational, 4-bit BCD in, 7-bit seg out, dash for invalid codes. It is instantiated once, on the muxed snapshot digit.

Test Plan:
1. Reset=1 for 2 cycles, then Reset=0 with Enable=0 -> seg=0, dp=0, digit_sel=0 and frame_start=0 indefinitely.
2. Digits 0,0,0,2,8 (0.28 mm), Enable=1, SCAN_DIV=64, BLANK_CYCLES=4 -> required response:
   - pos0 and pos1: seg=0x00 with digit_sel set;
   - pos2: seg=0x3F with dp=1;
   - pos3: seg=0x5B; pos4: seg=0x7F;
   - each digit is on for 60 cycles, followed by 4 dark cycles;
   - frame_start repeats every 320 cycles.
3. Change the digits to 1,2,3,4,5 at cycle 100 of a frame -> the old digits remain displayed through the frame end. The new code 0x06 appears on pos0 exactly at the next frame_start.
4. Leading zeros:
   - hundreds=0, tens=5 -> pos0=0x00, pos1=0x6D;
   - hundreds=1, tens=0 -> pos1=0x3F;
   - with LZB_EN=0 and digits 0,0 -> both positions show 0x3F.
5. Invalid digit: tenths=0xA -> pos3 seg=0x40; all other positions are unaffected.
6. Mid-frame interruptions:
   - Enable dropped during pos3 -> all outputs 0 from the next cycle; re-enabling restarts at pos0 with frame_start after 1 cycle.
   - Reset pulsed during pos1 -> same result.
